// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding, port indices and
// the default starvation limit.
package dmem_arb_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

    localparam logic PORT_CORE = 1'b0;
    localparam logic PORT_DBG  = 1'b1;

    localparam int STARVE_LIMIT_DEF = 4;

endpackage

// File: rtl/arb_prio2.sv
// Two-way priority picker: core first, debug when starved or when the memory is
// locked to debug. Grants are one-hot or zero.
module arb_prio2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       starve_ovr,
    input  logic       lock,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = '0;
        if (lock) begin
            gnt[PORT_DBG] = req[PORT_DBG];
        end else if (req[PORT_CORE] && !(starve_ovr && req[PORT_DBG])) begin
            gnt[PORT_CORE] = 1'b1;
        end else if (req[PORT_DBG]) begin
            gnt[PORT_DBG] = 1'b1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the core MEM stage and the
// debug/loader port, with starvation override and a debug burst lock.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW           = 5,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic          clk,
    input  logic          RN,

    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_gnt,
    output logic          c_rvalid,
    output logic [DW-1:0] c_rdata,

    input  logic          d_req,
    input  logic          d_we,
    input  logic          d_lock,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,

    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    arb_state_e state;
    logic [3:0] starve_cnt;
    logic       starve_ovr;
    logic [1:0] req;
    logic [1:0] gnt;
    logic       c_rd_p0;
    logic       d_rd_p0;
    logic       rd_live_p1;

    assign starve_ovr     = (starve_cnt == LIMIT);
    assign req[PORT_CORE] = c_req;
    assign req[PORT_DBG]  = d_req;

    arb_prio2 u_prio (
        .req        (req),
        .starve_ovr (starve_ovr),
        .lock       (state == ST_LOCKED),
        .gnt        (gnt)
    );

    assign c_gnt = gnt[PORT_CORE];
    assign d_gnt = gnt[PORT_DBG];

    // Stage p0: winner drives the memory directly, idle bus is all zeros
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (c_gnt) begin
            mem_en    = 1'b1;
            mem_we    = c_we;
            mem_addr  = c_addr;
            mem_wdata = c_wdata;
        end else if (d_gnt) begin
            mem_en    = 1'b1;
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end
    end

    assign c_rd_p0 = c_gnt && !c_we;
    assign d_rd_p0 = d_gnt && !d_we;

    always_ff @(posedge clk or negedge RN) begin
        if (!RN) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:   if (d_gnt && d_lock)   state <= ST_LOCKED;
                ST_LOCKED: if (!d_req || !d_lock) state <= ST_IDLE;
                default:                          state <= ST_IDLE;
            endcase
        end
    end

    // Debug waiting while the core keeps winning; saturates so the override holds
    always_ff @(posedge clk or negedge RN) begin
        if (!RN) begin
            starve_cnt <= '0;
        end else if (!d_req || d_gnt) begin
            starve_cnt <= '0;
        end else if (starve_cnt != LIMIT) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    // Stage p1: memory returns read data one cycle after the grant
    always_ff @(posedge clk or negedge RN) begin
        if (!RN) begin
            c_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
        end else begin
            c_rvalid <= c_rd_p0;
            d_rvalid <= d_rd_p0;
        end
    end

    assign rd_live_p1 = c_rvalid | d_rvalid;
    assign c_rdata    = rd_live_p1 ? mem_rdata : '0;
    assign d_rdata    = rd_live_p1 ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with an emulated DM array and a per-cycle
// reference model of grants, memory bus and read returns.
module tb_dmem_arbiter;

    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int LIMIT = 4;

    logic          clk = 1'b0;
    logic          RN;
    logic          c_req, c_we, d_req, d_we, d_lock;
    logic [AW-1:0] c_addr, d_addr;
    logic [DW-1:0] c_wdata, d_wdata;
    logic          c_gnt, c_rvalid, d_gnt, d_rvalid;
    logic [DW-1:0] c_rdata, d_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    int total = 0;
    int bad   = 0;
    bit run_chk = 1'b0;

    dmem_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .RN(RN),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .d_req(d_req), .d_we(d_we), .d_lock(d_lock), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Emulated DM array driven by the arbiter's memory bus
    logic [DW-1:0] dm [0:31];
    always @(posedge clk) begin
        if (mem_en && mem_we)  dm[mem_addr] <= mem_wdata;
        if (mem_en && !mem_we) mem_rdata    <= dm[mem_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reference model: ownership, starvation wait and expected read returns
    logic [DW-1:0] shadow [0:31];
    bit            m_locked;
    int            m_starve;
    bit            m_pend_c, m_pend_d;
    logic [DW-1:0] m_pend_val;

    always @(negedge clk) begin
        if (run_chk) begin
            bit            ex_c, ex_d, ex_we;
            logic [AW-1:0] ex_addr;
            logic [DW-1:0] ex_wd;
            if (!RN) begin
                m_locked = 0; m_starve = 0; m_pend_c = 0; m_pend_d = 0;
            end
            ex_c    = c_req && !m_locked && !(d_req && m_starve == LIMIT);
            ex_d    = d_req && !ex_c;
            ex_we   = ex_c ? c_we    : (ex_d ? d_we    : 1'b0);
            ex_addr = ex_c ? c_addr  : (ex_d ? d_addr  : '0);
            ex_wd   = ex_c ? c_wdata : (ex_d ? d_wdata : '0);
            chk("m_c_gnt", c_gnt, ex_c);
            chk("m_d_gnt", d_gnt, ex_d);
            chk("m_mem_en", mem_en, ex_c || ex_d);
            chk("m_mem_we", mem_we, ex_we);
            chk("m_mem_addr", mem_addr, ex_addr);
            chk("m_mem_wdata", mem_wdata, ex_wd);
            chk("m_c_rvalid", c_rvalid, m_pend_c);
            chk("m_d_rvalid", d_rvalid, m_pend_d);
            if (m_pend_c || m_pend_d) begin
                chk("m_c_rdata", c_rdata, m_pend_val);
                chk("m_d_rdata", d_rdata, m_pend_val);
            end
            if (!RN) begin
                chk("m_rst_c_rdata", c_rdata, 0);
                chk("m_rst_d_rdata", d_rdata, 0);
            end
            if ((ex_c || ex_d) && ex_we) shadow[ex_addr] = ex_wd;
            if ((ex_c || ex_d) && !ex_we) m_pend_val = shadow[ex_addr];
            if (RN) begin
                m_pend_c = ex_c && !c_we;
                m_pend_d = ex_d && !d_we;
                if (!d_req || ex_d) m_starve = 0;
                else if (m_starve < LIMIT) m_starve++;
                if (!m_locked) m_locked = ex_d && d_lock;
                else           m_locked = d_req && d_lock;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int waitc;
        RN = 1'b0;
        c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0;
        d_req = 0; d_we = 0; d_lock = 0; d_addr = '0; d_wdata = '0;
        for (int i = 0; i < 32; i++) begin
            dm[i]     = 32'h1000_0000 + i;
            shadow[i] = 32'h1000_0000 + i;
        end
        dm[5] = 32'h0000_0003;
        shadow[5] = 32'h0000_0003;
        m_locked = 0; m_starve = 0; m_pend_c = 0; m_pend_d = 0; m_pend_val = '0;
        run_chk = 1'b1;

        // Reset state with no requests
        cyc(); cyc();
        chk("rst_c_gnt", c_gnt, 0);
        chk("rst_d_gnt", d_gnt, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_c_rvalid", c_rvalid, 0);
        chk("rst_d_rvalid", d_rvalid, 0);
        chk("rst_c_rdata", c_rdata, 0);
        RN = 1'b1;
        cyc();

        // Core read of address 5
        c_req = 1; c_we = 0; c_addr = 5;
        #1;
        chk("rd_c_gnt", c_gnt, 1);
        chk("rd_mem_addr", mem_addr, 5);
        cyc();
        c_req = 0;
        #1;
        chk("rd_c_rvalid", c_rvalid, 1);
        chk("rd_c_rdata", c_rdata, 32'h3);
        chk("rd_d_rvalid", d_rvalid, 0);

        // Reset arrives while a core read is in flight
        c_req = 1; c_addr = 7;
        cyc();
        RN = 0; c_req = 0;
        #1;
        chk("midrst_c_rvalid", c_rvalid, 0);
        cyc();
        RN = 1;
        cyc();
        chk("midrst_after_rvalid", c_rvalid, 0);
        chk("midrst_after_c_gnt", c_gnt, 0);
        chk("midrst_after_d_gnt", d_gnt, 0);

        // Contention: core wins LIMIT times, then debug once, then core again
        c_req = 1; c_we = 0; c_addr = 1;
        d_req = 1; d_we = 0; d_addr = 9;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk($sformatf("cont_c_gnt_%0d", k), c_gnt, (k != 4));
            chk($sformatf("cont_d_gnt_%0d", k), d_gnt, (k == 4));
            cyc();
        end
        c_req = 0; d_req = 0;
        cyc();

        // Lock burst: debug writes 0..3 while core keeps requesting
        c_req = 1; c_we = 0; c_addr = 10;
        d_req = 1; d_we = 1;
        for (int b = 0; b < 4; b++) begin
            d_addr  = 5'(b);
            d_wdata = 32'hD0 + b;
            d_lock  = (b != 3);
            #1;
            waitc = 0;
            while (!d_gnt && waitc < 12) begin
                cyc();
                #1;
                waitc++;
            end
            chk($sformatf("lk_d_gnt_%0d", b), d_gnt, 1);
            chk($sformatf("lk_c_gnt_%0d", b), c_gnt, 0);
            chk($sformatf("lk_wait_%0d", b), waitc, (b == 0) ? 4 : 0);
            cyc();
        end
        d_req = 0; d_lock = 0;
        #1;
        chk("lk_release_c_gnt", c_gnt, 1);
        cyc();
        c_req = 0;
        cyc();

        // Core store then debug load of the same word
        c_req = 1; c_we = 1; c_addr = 2; c_wdata = 32'hA5;
        #1;
        chk("mix_c_gnt", c_gnt, 1);
        cyc();
        c_req = 0; c_we = 0;
        d_req = 1; d_we = 0; d_addr = 2;
        #1;
        chk("mix_d_gnt", d_gnt, 1);
        chk("mix_wr_no_rvalid", c_rvalid, 0);
        cyc();
        d_req = 0;
        #1;
        chk("mix_d_rvalid", d_rvalid, 1);
        chk("mix_d_rdata", d_rdata, 32'hA5);
        chk("mix_c_rvalid", c_rvalid, 0);

        // Alternating back-to-back reads
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) begin
                c_req = 1; c_we = 0; c_addr = 5'(i); d_req = 0;
            end else begin
                d_req = 1; d_we = 0; d_addr = 5'(i); c_req = 0;
            end
            #1;
            chk($sformatf("b2b_gnt_%0d", i), (i % 2 == 0) ? c_gnt : d_gnt, 1);
            if (i > 0) begin
                chk($sformatf("b2b_c_rvalid_%0d", i), c_rvalid, (i % 2 == 1));
                chk($sformatf("b2b_d_rvalid_%0d", i), d_rvalid, (i % 2 == 0));
            end
            if (i == 4) chk("b2b_d_rdata_addr3", d_rdata, 32'hD3);
            cyc();
        end
        c_req = 0; d_req = 0;
        #1;
        chk("b2b_last_d_rvalid", d_rvalid, 1);
        chk("b2b_last_d_rdata", d_rdata, 32'h3);
        cyc();
        cyc();
        run_chk = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port 32x32 data memory between two requesters: port 0, the core pipeline MEM stage (LW/SW), and port 1, a debug/loader port used to preload or inspect DM.
- The core has priority. A starvation counter guarantees the debug port eventually wins.
- A lock lets the debug port hold the memory for a burst.
- The block sits between the pipeline MEM stage and the DM array; the memory has 1-cycle read latency.

Parameters:
- AW, 5: address width (DM depth = 2**AW words).
- DW, 32: data width.
- STARVE_LIMIT, 4: consecutive denied debug cycles after which debug beats the core; range 1..15.

Ports:
- clk  in  1  clock, all state on posedge.
- RN  in  1  reset; asynchronous, active-low.
- c_req  in  1  core request.
- c_we  in  1  core write enable (1 = SW, 0 = LW).
- c_addr  in  AW  core word address.
- c_wdata  in  DW  core store data.
- c_gnt  out  1  core request accepted this cycle (combinational).
- c_rvalid  out  1  core read data valid (registered).
- c_rdata  out  DW  core read data.
- d_req  in  1  debug request.
- d_we  in  1  debug write enable.
- d_lock  in  1  debug asks to keep ownership after the current grant.
- d_addr  in  AW  debug word address.
- d_wdata  in  DW  debug write data.
- d_gnt  out  1  debug request accepted this cycle (combinational).
- d_rvalid  out  1  debug read data valid (registered).
- d_rdata  out  DW  debug read data.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data, valid the cycle after mem_en with mem_we=0.

Behaviour:
- Handshake:
  - A requester holds req and its fields stable until it sees gnt high in the same cycle.
  - At most one gnt per cycle.
  - mem_* is driven combinationally from the winner: mem_en = c_gnt | d_gnt. With no grant, mem_en/mem_we = 0 and addr/wdata = 0.
- FSM states:
  - IDLE (shared): winner chosen by the arbitration rules below.
  - LOCKED: only debug may be granted; c_gnt = 0.
  - IDLE -> LOCKED on d_gnt & d_lock.
  - LOCKED -> IDLE when d_req = 0 or d_lock = 0 at a clock edge. The access granted in that cycle, if any, still completes.
- Arbitration in IDLE:
  - c_req only -> core.
  - d_req only -> debug.
  - Both requesting, starve_cnt < STARVE_LIMIT -> core.
  - Both requesting, starve_cnt == STARVE_LIMIT -> debug.
- starve_cnt (4 bit):
  - Increments on d_req & !d_gnt.
  - Clears on d_gnt or !d_req.
  - Saturates at STARVE_LIMIT.
- Read return:
  - A granted read (we=0) sets the matching x_rvalid for exactly the next cycle.
  - That cycle, both c_rdata and d_rdata carry mem_rdata; only the x_rvalid qualifies which port owns it.
  - Writes never raise rvalid.
  - Back-to-back grants give back-to-back rvalids with 1-cycle latency, so no internal queue is needed.
- Simultaneous events:
  - A new grant in the same cycle as a pending rvalid is legal and independent.
  - Lock request while the core wins (starve_cnt below limit): lock is ignored, since d_gnt = 0.
- Reset (RN low, asynchronous, also mid-operation):
  - State = IDLE, starve_cnt = 0, c_rvalid = d_rvalid = 0.
  - Any in-flight read is dropped with no rvalid after release.
  - c_rdata/d_rdata are 0 while in reset.
  - Combinational outputs follow inputs with state = IDLE.
- Widths: addresses pass unmodified. No wrap or bounds logic; DM depth equals 2**AW.

Decomposition:
- Shared package dmem_arb_pkg holds:
  - FSM state encoding (ST_IDLE, ST_LOCKED).
  - Port index constants (PORT_CORE = 0, PORT_DBG = 1).
  - Default STARVE_LIMIT.
- One natural sub-module: arb_prio2, a combinational 2-way priority picker that takes starve-override and lock inputs and returns one-hot grants. Counter, FSM and rvalid registers stay in dmem_arbiter.

Test Plan:
- Reset: RN = 0 mid-read (c_req = 1, c_we = 0 granted the previous cycle) -> c_rvalid stays 0 after RN = 1; all grants 0 with no req.
- Core read: c_req = 1, c_addr = 5, memory[5] = 32'h0000_0003 -> c_gnt = 1 the same cycle; next cycle c_rvalid = 1, c_rdata = 3, d_rvalid = 0.
- Contention/starvation: both req held, STARVE_LIMIT = 4 -> core granted cycles 0-3; debug granted cycle 4; starve_cnt back to 0 at cycle 5; core granted cycle 5.
- Lock burst: debug writes addr 0..3 with d_lock = 1 and c_req held high -> 4 consecutive d_gnt, c_gnt = 0 throughout. d_lock drops on the 4th beat -> c_gnt = 1 the following cycle.
- Write/read mix: core SW addr 2 = 32'hA5 on cycle n; debug LW addr 2 on cycle n+1 -> d_rvalid at n+2 with d_rdata = 32'hA5; no rvalid for the write.
- Back-to-back reads: alternating core/debug reads on consecutive cycles -> rvalids alternate every cycle, each one cycle after its grant.
